button_event_decoder: RTL and testbench

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/button_pkg.sv | 14 +
 rtl/button_event_decoder.sv | 110 +++++++++++
 tb/tb_button_event_decoder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and default timing for the button event decoder.
package button_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    PRESS    = 2'd2,
    LONG     = 2'd3
  } button_state_e;

  localparam int DEFAULT_LONG_CYCLES   = 8;
  localparam int DEFAULT_REPEAT_CYCLES = 4;

endpackage

// File: rtl/button_event_decoder.sv
// Turns a clean, clk-synchronous button level into press/click/long/repeat/release
// strobes. One FSM plus one hold counter; every output is registered.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
  parameter int CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_level,
  output logic       press_pulse,
  output logic       click_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       release_pulse,
  output logic       held,
  output logic [1:0] state_dbg
);

  // Terminal counts in CNT_W+1 bits so a threshold of 2^CNT_W is representable.
  localparam logic [CNT_W:0] LONG_TERM   = (CNT_W+1)'(LONG_CYCLES);
  localparam logic [CNT_W:0] REPEAT_TERM = (CNT_W+1)'(REPEAT_CYCLES);

  button_state_e    state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W:0]   cnt_inc;
  logic             press_n, click_n, long_n, repeat_n, release_n, held_n;

  assign cnt_inc   = {1'b0, cnt} + (CNT_W+1)'(1);
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    press_n    = 1'b0;
    click_n    = 1'b0;
    long_n     = 1'b0;
    repeat_n   = 1'b0;
    release_n  = 1'b0;
    case (state)
      WAIT_LOW: begin
        if (!btn_level) state_next = IDLE;
      end
      IDLE: begin
        if (btn_level) begin
          state_next = PRESS;
          press_n    = 1'b1;
          cnt_next   = CNT_W'(1);
        end
      end
      PRESS: begin
        // A low sample is checked first so it always wins over a terminal count.
        if (!btn_level) begin
          state_next = IDLE;
          click_n    = 1'b1;
          release_n  = 1'b1;
          cnt_next   = '0;
        end else if (cnt_inc == LONG_TERM) begin
          state_next = LONG;
          long_n     = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc[CNT_W-1:0];
        end
      end
      LONG: begin
        if (!btn_level) begin
          state_next = IDLE;
          release_n  = 1'b1;
          cnt_next   = '0;
        end else if (cnt_inc == REPEAT_TERM) begin
          repeat_n = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = cnt_inc[CNT_W-1:0];
        end
      end
      default: begin
        state_next = WAIT_LOW;
        cnt_next   = '0;
      end
    endcase
    held_n = (state_next == PRESS) || (state_next == LONG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_LOW;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      press_pulse   <= press_n;
      click_pulse   <= click_n;
      long_pulse    <= long_n;
      repeat_pulse  <= repeat_n;
      release_pulse <= release_n;
      held          <= held_n;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: a run-length model predicts each cycle's outputs
// into a queue; scenario tasks pop and compare after every clock.
module tb_button_event_decoder;
  import button_pkg::*;

  localparam int L = 8;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_level;
  logic       press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse, held;
  logic [1:0] state_dbg;

  logic [5:0] exp_q[$];
  int         n_compared   = 0;
  int         n_mismatched = 0;

  int         m_run;
  bit         m_need_low;

  wire [5:0] obs = {press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse, held};

  button_event_decoder #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .CNT_W(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .click_pulse  (click_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .release_pulse(release_pulse),
    .held         (held),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial forever #5 clk = ~clk;
  initial begin
    rst       = 1'b1;
    btn_level = 1'b0;
  end

  // Model: counts consecutive high samples since the last low; outputs are
  // {press, click, long, repeat, release, held} as seen after that sample's edge.
  function automatic logic [5:0] model_step(input logic r, input logic b);
    logic p, c, lg, rp, rl, h;
    p = 0; c = 0; lg = 0; rp = 0; rl = 0; h = 0;
    if (r) begin
      m_need_low = 1;
      m_run      = 0;
    end else if (m_need_low) begin
      if (!b) m_need_low = 0;
    end else if (b) begin
      m_run++;
      p  = (m_run == 1);
      lg = (m_run == L);
      rp = (m_run > L) && (((m_run - L) % R) == 0);
      h  = 1;
    end else begin
      if (m_run > 0) begin
        rl = 1;
        c  = (m_run < L);
      end
      m_run = 0;
    end
    return {p, c, lg, rp, rl, h};
  endfunction

  // driver: apply one sample on the falling edge, predict, then sample after the rising edge
  task automatic drive(input logic r, input logic b);
    @(negedge clk);
    rst       = r;
    btn_level = b;
    exp_q.push_back(model_step(r, b));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i == 1) ? 1'b1 : 1'b0);
      exp = exp_q.pop_front();
      n_compared++;
      if (obs !== exp) begin
        n_mismatched++;
        $display("FAIL reset_outputs[%0d]: got %b expected %b", i, obs, exp);
      end
      n_compared++;
      if (state_dbg !== WAIT_LOW) begin
        n_mismatched++;
        $display("FAIL reset_state[%0d]: got %0d expected %0d", i, state_dbg, WAIT_LOW);
      end
    end
  endtask

  task automatic test_short_click();
    logic [5:0] exp;
    logic [1:0] pat[$];
    int held_cycles = 0, longs = 0, clicks = 0;
    pat.push_back(2'b10);
    repeat (2) pat.push_back(2'b00);
    repeat (3) pat.push_back(2'b01);
    repeat (2) pat.push_back(2'b00);
    foreach (pat[i]) begin
      drive(pat[i][1], pat[i][0]);
      exp = exp_q.pop_front();
      n_compared++;
      if (obs !== exp) begin
        n_mismatched++;
        $display("FAIL short_click[%0d]: got %b expected %b", i, obs, exp);
      end
      held_cycles += int'(held);
      longs       += int'(long_pulse);
      clicks      += int'(click_pulse & release_pulse);
    end
    n_compared++;
    if (held_cycles !== 3) begin
      n_mismatched++;
      $display("FAIL short_click_held_cycles: got %0d expected 3", held_cycles);
    end
    n_compared++;
    if (longs !== 0 || clicks !== 1) begin
      n_mismatched++;
      $display("FAIL short_click_strobes: got long=%0d click=%0d expected long=0 click=1", longs, clicks);
    end
  endtask

  task automatic test_boundary();
    logic [5:0] exp;
    int clicks, longs, releases;
    for (int n = L - 1; n <= L; n++) begin
      clicks = 0; longs = 0; releases = 0;
      for (int i = 0; i < n + 2; i++) begin
        drive(1'b0, (i < n) ? 1'b1 : 1'b0);
        exp = exp_q.pop_front();
        n_compared++;
        if (obs !== exp) begin
          n_mismatched++;
          $display("FAIL boundary_%0d[%0d]: got %b expected %b", n, i, obs, exp);
        end
        clicks   += int'(click_pulse);
        longs    += int'(long_pulse);
        releases += int'(release_pulse);
      end
      n_compared++;
      if (clicks !== ((n < L) ? 1 : 0) || longs !== ((n < L) ? 0 : 1) || releases !== 1) begin
        n_mismatched++;
        $display("FAIL boundary_count_%0d: got click=%0d long=%0d release=%0d", n, clicks, longs, releases);
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic [5:0] exp;
    int repeats = 0, clicks = 0;
    for (int i = 0; i < 22; i++) begin
      drive(1'b0, (i < 20) ? 1'b1 : 1'b0);
      exp = exp_q.pop_front();
      n_compared++;
      if (obs !== exp) begin
        n_mismatched++;
        $display("FAIL auto_repeat[%0d]: got %b expected %b", i, obs, exp);
      end
      repeats += int'(repeat_pulse);
      clicks  += int'(click_pulse);
    end
    n_compared++;
    if (repeats !== 3 || clicks !== 0) begin
      n_mismatched++;
      $display("FAIL auto_repeat_count: got repeat=%0d click=%0d expected repeat=3 click=0", repeats, clicks);
    end
  endtask

  task automatic test_low_priority();
    logic [5:0] exp;
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, (i < 11) ? 1'b1 : 1'b0);
      exp = exp_q.pop_front();
      n_compared++;
      if (obs !== exp) begin
        n_mismatched++;
        $display("FAIL low_priority[%0d]: got %b expected %b", i, obs, exp);
      end
      if (i == 11) begin
        n_compared++;
        if (repeat_pulse !== 1'b0 || release_pulse !== 1'b1) begin
          n_mismatched++;
          $display("FAIL low_priority_drop: got repeat=%b release=%b expected repeat=0 release=1",
                   repeat_pulse, release_pulse);
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [5:0] exp;
    logic [1:0] pat[$];
    pat.push_back(2'b00);
    repeat (4) pat.push_back(2'b01);
    pat.push_back(2'b11);
    repeat (4) pat.push_back(2'b01);
    pat.push_back(2'b00);
    repeat (2) pat.push_back(2'b01);
    repeat (2) pat.push_back(2'b00);
    foreach (pat[i]) begin
      drive(pat[i][1], pat[i][0]);
      exp = exp_q.pop_front();
      n_compared++;
      if (obs !== exp) begin
        n_mismatched++;
        $display("FAIL reset_mid_hold[%0d]: got %b expected %b", i, obs, exp);
      end
      if (i == 11) begin
        n_compared++;
        if (press_pulse !== 1'b1) begin
          n_mismatched++;
          $display("FAIL reset_mid_hold_repress: got press=%b expected 1", press_pulse);
        end
      end
    end
  endtask

  task automatic test_power_up_high();
    logic [5:0] exp;
    logic [1:0] pat[$];
    int early_press = 0;
    repeat (3) pat.push_back(2'b11);
    repeat (6) pat.push_back(2'b01);
    pat.push_back(2'b00);
    repeat (2) pat.push_back(2'b01);
    pat.push_back(2'b00);
    foreach (pat[i]) begin
      drive(pat[i][1], pat[i][0]);
      exp = exp_q.pop_front();
      n_compared++;
      if (obs !== exp) begin
        n_mismatched++;
        $display("FAIL power_up_high[%0d]: got %b expected %b", i, obs, exp);
      end
      if (i < 9) early_press += int'(press_pulse | held);
    end
    n_compared++;
    if (early_press !== 0) begin
      n_mismatched++;
      $display("FAIL power_up_high_no_press: got %0d press/held cycles expected 0", early_press);
    end
  endtask

  task automatic test_random();
    logic [5:0] exp;
    logic b = 1'b0;
    logic r;
    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 11) == 0) b = ~b;
      drive(r, b);
      exp = exp_q.pop_front();
      n_compared++;
      if (obs !== exp) begin
        n_mismatched++;
        $display("FAIL random[%0d]: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_click();
    test_boundary();
    test_auto_repeat();
    test_low_priority();
    test_reset_mid_hold();
    test_power_up_high();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
